// File: rtl/booth_mac_acc_pkg.sv
// Shared types and constants for the Booth product accumulator and its helpers.
// Holds the FSM state encoding, default widths and saturation-limit helpers.
// Limit helpers return 64-bit patterns; callers size-cast them to their ACC_W.
package booth_mac_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no terms accepted yet
    ST_ACC  = 2'd1,  // at least one term accumulated
    ST_OUT  = 2'd2   // result held for downstream
  } state_t;

  localparam int PROD_W_DEF = 33;
  localparam int ACC_W_DEF  = 40;
  localparam int CNT_W_DEF  = 8;

  // Most positive ACC_W-bit signed value, +2^(w-1)-1.
  function automatic logic [63:0] acc_max_f(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative ACC_W-bit signed value, -2^(w-1); correct once truncated to w bits.
  function automatic logic [63:0] acc_min_f(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/booth_mac_acc_sat_add.sv
// Saturating signed add: sign-extends add_in to ACC_W and adds it to acc_in.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when to register sum_out.
// Ports: acc_in (ACC_W, signed), add_in (PROD_W, signed),
//        sum_out (ACC_W, clamped sum), ovf (clamp applied this add).
module booth_mac_acc_sat_add
  import booth_mac_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [PROD_W-1:0] add_in,
  output logic [ACC_W-1:0]  sum_out,
  output logic              ovf
);

  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(acc_max_f(ACC_W));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(acc_min_f(ACC_W));

  logic [ACC_W:0] add_ext;
  logic [ACC_W:0] sum_wide;

  always_comb begin
    // One guard bit above ACC_W: the add itself can never wrap.
    add_ext  = {{(ACC_W + 1 - PROD_W){add_in[PROD_W-1]}}, add_in};
    sum_wide = {acc_in[ACC_W-1], acc_in} + add_ext;
    // Guard bit and ACC_W MSB disagree only when the true sum left the ACC_W range;
    // the guard bit is then the true sign and picks the clamp direction.
    ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (ovf) begin
      sum_out = sum_wide[ACC_W] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_out = sum_wide[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/booth_mac_acc.sv
// Accumulates a burst of signed multiplier products into a saturating sum.
// Latency: result valid 1 cycle after the accept carrying prod_last.
// Backpressure: prod_ready low while a result is held; released after the res handshake.
// Ports: clk, rst (async active-low); prod_in/prod_valid/prod_last/prod_ready product
//        input; clr aborts the open burst; res_data/res_count/res_sat/res_valid/res_ready
//        result output.
module booth_mac_acc
  import booth_mac_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready,
  input  logic              clr,
  output logic [ACC_W-1:0]  res_data,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_sat,
  output logic              res_valid,
  input  logic              res_ready
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [ACC_W-1:0] sum;
  logic             sum_ovf;

  booth_mac_acc_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .acc_in  (acc_q),
    .add_in  (prod_in),
    .sum_out (sum),
    .ovf     (sum_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      ST_IDLE, ST_ACC: begin
        if (clr) begin
          // Abort wins over a same-cycle product; that product is dropped.
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else if (prod_valid) begin
          acc_d   = sum;
          sat_d   = sat_q | sum_ovf;
          // Term count sticks at all-ones; that alone is not a saturation event.
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          state_d = prod_last ? ST_OUT : ST_ACC;
        end
      end
      ST_OUT: begin
        // Registers stay frozen (clr ignored) until the result is taken.
        if (res_ready) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign prod_ready = (state_q != ST_OUT);
  assign res_valid  = (state_q == ST_OUT);
  assign res_data   = acc_q;
  assign res_count  = cnt_q;
  assign res_sat    = sat_q;

endmodule

// File: tb/tb_booth_mac_acc.sv
module tb_booth_mac_acc;

  localparam int PW = 33;
  localparam int AW = 34;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] prod_in;
  logic          prod_valid;
  logic          prod_last;
  logic          prod_ready;
  logic          clr;
  logic [AW-1:0] res_data;
  logic [CW-1:0] res_count;
  logic          res_sat;
  logic          res_valid;
  logic          res_ready;

  booth_mac_acc #(.PROD_W(PW), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ready (prod_ready),
    .clr        (clr),
    .res_data   (res_data),
    .res_count  (res_count),
    .res_sat    (res_sat),
    .res_valid  (res_valid),
    .res_ready  (res_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the burst.
  typedef struct {
    logic [AW-1:0] d;
    logic [CW-1:0] c;
    logic          s;
  } exp_t;

  exp_t   sb[$];
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_sat = 0;
  int     exp_rise_cyc = -1;
  bit     rand_rdy = 0;

  localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (AW - 1));
  localparam int     CMAX = (1 << CW) - 1;

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_sat = 0;
  endtask

  task automatic model_accept(input logic [PW-1:0] p, input logic last);
    longint s;
    exp_t   e;
    s = m_acc + longint'($signed(p));
    if (s > MAXV) begin
      s = MAXV;
      m_sat = 1;
    end else if (s < MINV) begin
      s = MINV;
      m_sat = 1;
    end
    m_acc = s;
    if (m_cnt < CMAX) m_cnt++;
    if (last) begin
      e.d = AW'(m_acc);
      e.c = CW'(m_cnt);
      e.s = m_sat;
      sb.push_back(e);
      model_clear();
    end
  endtask

  // Offer one product; wait (bounded) until it is taken.
  task automatic send(input logic [PW-1:0] p, input logic last, input logic with_clr);
    int n = 0;
    bit done = 0;
    prod_in    = p;
    prod_valid = 1'b1;
    prod_last  = last;
    clr        = with_clr;
    while (!done) begin
      @(negedge clk);
      if (prod_ready) begin
        if (with_clr) model_clear();
        else begin
          model_accept(p, last);
          if (last) exp_rise_cyc = cyc + 1;
        end
        done = 1;
      end else if (++n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=prod_ready_low required=accept_within_200");
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    clr        = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_data"},  res_data,  0);
    chk({tag, "_count"}, res_count, 0);
    chk({tag, "_sat"},   res_sat,   0);
  endtask

  // Apply reset mid-cycle and confirm outputs clear before any clock edge.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero_outputs(tag);
    sb.delete();
    model_clear();
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_prod_ready"}, prod_ready, 1);
  endtask

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      res_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares every presented result against the scoreboard head.
  logic prev_v  = 1'b0;
  logic prev_hs = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      chk("prod_ready_vs_valid", prod_ready, !res_valid);
      if (prev_hs) begin
        chk("post_hs_valid", res_valid, 0);
        chk("post_hs_data",  res_data,  0);
        chk("post_hs_count", res_count, 0);
        chk("post_hs_sat",   res_sat,   0);
      end
      if (res_valid) begin
        if (!prev_v) chk("latency", cyc, exp_rise_cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=data_%0d required=no_result", res_data);
        end else begin
          chk("res_data",  res_data,  sb[0].d);
          chk("res_count", res_count, sb[0].c);
          chk("res_sat",   res_sat,   sb[0].s);
          if (res_ready) void'(sb.pop_front());
        end
      end
      prev_hs = res_valid && res_ready;
      prev_v  = res_valid;
    end else begin
      prev_hs = 1'b0;
      prev_v  = 1'b0;
    end
  end

  initial begin
    int n;
    rst        = 1'b0;
    prod_in    = '0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    clr        = 1'b0;
    res_ready  = 1'b1;
    #8;
    check_zero_outputs("reset");
    #4;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_prod_ready", prod_ready, 1);

    // Basic three-term burst.
    send(PW'(100), 0, 0);
    send(PW'(-30), 0, 0);
    send(PW'(7), 1, 0);
    wait_cycles(3);

    // Positive overflow clamps, then a fresh burst is unsaturated.
    for (int i = 0; i < 8; i++) send(PW'(64'd1 << 30), (i == 7), 0);
    wait_cycles(2);
    send(PW'(-5), 1, 0);
    wait_cycles(2);

    // Single-term burst straight from idle.
    send(PW'(-1073741824), 1, 0);
    wait_cycles(2);

    // Held result: back-pressure, ignored product pulse and ignored clr.
    res_ready = 1'b0;
    send(PW'(5), 0, 0);
    send(PW'(7), 1, 0);
    wait_cycles(1);
    prod_in = PW'(99); prod_valid = 1'b1; prod_last = 1'b1;
    wait_cycles(1);
    prod_valid = 1'b0; prod_last = 1'b0; clr = 1'b1;
    wait_cycles(1);
    clr = 1'b0;
    wait_cycles(2);
    chk("hold_valid", res_valid, 1);
    chk("hold_data", res_data, 12);
    res_ready = 1'b1;
    wait_cycles(2);
    chk("hold_release_ready", prod_ready, 1);

    // clr beats a simultaneous last product.
    send(PW'(50), 0, 0);
    send(PW'(60), 0, 0);
    send(PW'(999), 1, 1);
    chk("clr_data", res_data, 0);
    chk("clr_count", res_count, 0);
    chk("clr_valid", res_valid, 0);
    wait_cycles(2);
    send(PW'(4), 1, 0);
    wait_cycles(2);

    // Reset mid-accumulation and mid-hold.
    send(PW'(123), 0, 0);
    chk("pre_reset_acc", res_data, 123);
    mid_reset("rst_acc");
    res_ready = 1'b0;
    send(PW'(9), 1, 0);
    mid_reset("rst_out");
    res_ready = 1'b1;

    // Term counter saturation.
    for (int i = 0; i < 260; i++) send(PW'(1), (i == 259), 0);
    wait_cycles(2);

    // Randomized bursts with random result back-pressure and occasional aborts.
    rand_rdy = 1'b1;
    for (int b = 0; b < 40; b++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        logic [PW-1:0] p;
        if ($urandom_range(0, 3) == 0) p = PW'($signed(16'($urandom)));
        else p = {1'($urandom_range(0, 1)), 32'($urandom)};
        send(p, (i == len - 1), ($urandom_range(0, 15) == 0));
      end
    end
    rand_rdy = 1'b0;
    #1;
    res_ready = 1'b1;

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      wait_cycles(1);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    wait_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
